// File: rtl/barrel_shifter_pipe_if.sv
// Streaming handshake bundle for the pipelined barrel shifter.
// The master drives operands and accepts results; the slave is the shifter.
interface barrel_shifter_pipe_if #(
    parameter int  WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_amount;
    logic             direction;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;

    modport master (
        output in_valid, data_in, shift_amount, direction, mode, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, shift_amount, direction, mode, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: logical / arithmetic / rotate, left or right.
// Stage k applies a shift of 2^k when bit k of the shift amount is set, so
// a WIDTH-bit word needs SHW = log2(WIDTH) registered stages. The whole
// pipe advances in lockstep and stalls as a unit under backpressure.
module barrel_shifter_pipe #(
    parameter int  WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input logic                 clk,
    input logic                 rst,
    barrel_shifter_pipe_if.slave bus
);
    // Per-beat control carried down the pipe alongside the data. The sign is
    // latched from the original operand so arithmetic right shifts fill with it.
    typedef struct packed {
        logic       dir;
        logic [1:0] mode;
        logic       sign;
    } ctrl_t;

    logic           adv;
    logic [SHW:0]   vld_pipe;

    assign vld_pipe[0]   = bus.in_valid;
    assign adv           = !vld_pipe[SHW] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[SHW];

    // One power-of-two step. Mode 11 and arithmetic-left fall through to logical.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input int               n,
        input ctrl_t            c
    );
        logic [WIDTH-1:0] fill;
        fill = (c.dir && c.mode == 2'b01 && c.sign) ? ~({WIDTH{1'b1}} >> n) : '0;
        if (c.mode == 2'b10)
            return c.dir ? ((d >> n) | (d << (WIDTH - n))) : ((d << n) | (d >> (WIDTH - n)));
        return c.dir ? ((d >> n) | fill) : (d << n);
    endfunction

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_q;
        logic [SHW-1:k]   amt_in;
        ctrl_t            c_in;
        logic             vld_q;

        if (k == 0) begin : g_src
            assign d_in   = bus.data_in;
            assign amt_in = bus.shift_amount;
            assign c_in   = '{dir: bus.direction, mode: bus.mode, sign: bus.data_in[WIDTH-1]};
        end else begin : g_src
            assign d_in   = g_stage[k-1].d_q;
            assign amt_in = g_stage[k-1].g_fwd.amt_q;
            assign c_in   = g_stage[k-1].g_fwd.c_q;
        end

        // Data and valid advance together; bubbles move like real beats.
        always_ff @(posedge clk) begin
            if (rst) begin
                d_q   <= '0;
                vld_q <= 1'b0;
            end else if (adv) begin
                vld_q <= vld_pipe[k];
                d_q   <= amt_in[k] ? shift_stage(d_in, 1 << k, c_in) : d_in;
            end
        end

        assign vld_pipe[k+1] = vld_q;

        // Only the shift bits still to be applied travel on; the last stage
        // has no consumer for its control, so it keeps none.
        if (k < SHW - 1) begin : g_fwd
            logic [SHW-1:k+1] amt_q;
            ctrl_t            c_q;

            // Control advances in lockstep with the data register above.
            always_ff @(posedge clk) begin
                if (rst) begin
                    amt_q <= '0;
                    c_q   <= '0;
                end else if (adv) begin
                    amt_q <= amt_in[SHW-1:k+1];
                    c_q   <= c_in;
                end
            end
        end
    end

    assign bus.data_out = g_stage[SHW-1].d_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe, with an 8-bit and a 16-bit instance.
// Expected results are pushed as beats are accepted; a negedge monitor pops and
// compares on every output transfer and also watches handshake and hold rules.
module tb_barrel_shifter_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    barrel_shifter_pipe_if #(.WIDTH(8))  b8 ();
    barrel_shifter_pipe_if #(.WIDTH(16)) b16 ();

    barrel_shifter_pipe #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
    barrel_shifter_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

    typedef struct {
        logic [15:0] exp;
        int          acc;
    } exp_t;

    exp_t        q8[$];
    exp_t        q16[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          lat_exact = 1'b1;
    bit          rand_bp = 1'b0;
    bit          pv[2];
    logic [15:0] pd[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Bit-by-bit reference: each output bit is looked up at its source index.
    function automatic logic [15:0] ref_shift(int w, logic [15:0] d, int n, logic dir, logic [1:0] m);
        logic [15:0] r;
        int          src;
        r = '0;
        for (int i = 0; i < w; i++) begin
            src = dir ? i + n : i - n;
            if (m == 2'b10)                r[i] = d[(src + w) % w];
            else if (src >= 0 && src < w)  r[i] = d[src];
            else if (dir && m == 2'b01)    r[i] = d[w-1];
            else                           r[i] = 1'b0;
        end
        return r;
    endfunction

    task automatic fail_line(string name, logic [15:0] act, logic [15:0] req);
        failures++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Drive one beat, wait (bounded) for acceptance, and log its expectation.
    task automatic send(int w, logic [15:0] d, int n, logic dir, logic [1:0] m, logic [15:0] exp);
        bit acc = 1'b0;
        if (w == 8) begin
            b8.in_valid = 1'b1; b8.data_in = d[7:0]; b8.shift_amount = 3'(n);
            b8.direction = dir; b8.mode = m;
        end else begin
            b16.in_valid = 1'b1; b16.data_in = d; b16.shift_amount = 4'(n);
            b16.direction = dir; b16.mode = m;
        end
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = (w == 8) ? b8.in_ready : b16.in_ready;
        end
        checks++;
        if (!acc) fail_line("accept_timeout", 16'h0, 16'h1);
        else if (w == 8) q8.push_back('{exp, cyc + 1});
        else q16.push_back('{exp, cyc + 1});
        @(posedge clk); #1;
        if (w == 8) b8.in_valid = 1'b0; else b16.in_valid = 1'b0;
    endtask

    task automatic mon_step(int w);
        int          i;
        logic        v, r, ir;
        logic [15:0] d;
        exp_t        e;
        i = (w == 8) ? 0 : 1;
        if (w == 8) begin v = b8.out_valid;  r = b8.out_ready;  ir = b8.in_ready;  d = {8'h00, b8.data_out}; end
        else        begin v = b16.out_valid; r = b16.out_ready; ir = b16.in_ready; d = b16.data_out; end
        if (rst) begin
            pv[i] = 1'b0;
            return;
        end
        checks++;
        if ($isunknown({v, ir, d})) fail_line("x_on_outputs", d, 16'h0);
        checks++;
        if (ir !== (!v || r)) fail_line("in_ready_rule", {15'h0, ir}, {15'h0, !v || r});
        if (pv[i] && v) begin
            checks++;
            if (d !== pd[i]) fail_line("hold_stable", d, pd[i]);
        end
        if (v && r) begin
            checks++;
            if ((w == 8 ? q8.size() : q16.size()) == 0) fail_line("unexpected_beat", d, 16'h0);
            else begin
                e = (w == 8) ? q8.pop_front() : q16.pop_front();
                if (d !== e.exp) fail_line(w == 8 ? "data8" : "data16", d, e.exp);
                if (lat_exact) begin
                    checks++;
                    if (cyc - e.acc != (w == 8 ? 2 : 3))
                        fail_line("latency", 16'(cyc - e.acc), 16'(w == 8 ? 2 : 3));
                end
            end
        end
        pv[i] = v && !r;
        pd[i] = d;
    endtask

    always @(negedge clk) begin
        mon_step(8);
        mon_step(16);
    end

    // Random output backpressure for the 8-bit soak.
    initial begin
        wait (rand_bp);
        while (rand_bp) begin
            @(posedge clk); #1;
            b8.out_ready = ($urandom_range(0, 3) != 0);
        end
        b8.out_ready = 1'b1;
    end

    initial begin
        logic [15:0] d;
        int          n;
        logic        dir;
        logic [1:0]  m;

        b8.in_valid = 0;  b8.data_in = 0;  b8.shift_amount = 0;  b8.direction = 0;  b8.mode = 0;  b8.out_ready = 1;
        b16.in_valid = 0; b16.data_in = 0; b16.shift_amount = 0; b16.direction = 0; b16.mode = 0; b16.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (b8.out_valid !== 1'b0) fail_line("reset_out_valid", {15'h0, b8.out_valid}, 16'h0);
        if (b8.data_out !== 8'h00) fail_line("reset_data_out", {8'h0, b8.data_out}, 16'h0);
        if (b8.in_ready !== 1'b1)  fail_line("reset_in_ready", {15'h0, b8.in_ready}, 16'h1);
        @(posedge clk); #1;

        // Single beat with exact latency.
        send(8, 16'hAA, 1, 1'b1, 2'b00, 16'h55);
        repeat (5) @(posedge clk); #1;

        // Back-to-back beats.
        send(8, 16'hAA, 3, 1'b1, 2'b01, 16'hF5);
        send(8, 16'h96, 2, 1'b0, 2'b10, 16'h5A);
        send(8, 16'h96, 3, 1'b1, 2'b10, 16'hD2);
        send(8, 16'h96, 4, 1'b0, 2'b00, 16'h60);
        send(8, 16'h96, 1, 1'b0, 2'b01, 16'h2C);
        repeat (5) @(posedge clk); #1;

        // Zero shift in every mode and direction.
        for (int mm = 0; mm < 4; mm++)
            for (int dd = 0; dd < 2; dd++)
                send(8, 16'h81, 0, dd[0], mm[1:0], 16'h81);
        repeat (5) @(posedge clk); #1;

        // Backpressure with 4 beats queued against a stalled output.
        lat_exact = 1'b0;
        b8.out_ready = 1'b0;
        fork
            begin
                send(8, 16'hC3, 1, 1'b1, 2'b01, ref_shift(8, 16'hC3, 1, 1'b1, 2'b01));
                send(8, 16'h5A, 5, 1'b0, 2'b10, ref_shift(8, 16'h5A, 5, 1'b0, 2'b10));
                send(8, 16'h81, 7, 1'b1, 2'b11, ref_shift(8, 16'h81, 7, 1'b1, 2'b11));
                send(8, 16'hF0, 6, 1'b1, 2'b01, ref_shift(8, 16'hF0, 6, 1'b1, 2'b01));
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                checks++;
                if (b8.in_ready !== 1'b0) fail_line("stall_in_ready", {15'h0, b8.in_ready}, 16'h0);
                @(posedge clk); #1;
                b8.out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk); #1;
        lat_exact = 1'b1;

        // Reset while two beats are in flight.
        send(8, 16'h3C, 2, 1'b0, 2'b00, 16'hF0);
        send(8, 16'h3C, 1, 1'b1, 2'b00, 16'h1E);
        rst = 1'b1;
        q8.delete();
        q16.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (b8.out_valid !== 1'b0) fail_line("midreset_out_valid", {15'h0, b8.out_valid}, 16'h0);
        if (b8.data_out !== 8'h00) fail_line("midreset_data_out", {8'h0, b8.data_out}, 16'h0);
        repeat (8) @(posedge clk); #1;

        // 16-bit instance: directed, then random with exact 4-stage latency.
        send(16, 16'h8001, 15, 1'b1, 2'b01, 16'hFFFF);
        send(16, 16'h8001, 1, 1'b0, 2'b10, 16'h0003);
        for (int b = 0; b < 40; b++) begin
            d = 16'($urandom); n = $urandom_range(0, 15); dir = 1'($urandom); m = 2'($urandom);
            send(16, d, n, dir, m, ref_shift(16, d, n, dir, m));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        repeat (8) @(posedge clk); #1;

        // 8-bit random soak under random backpressure.
        lat_exact = 1'b0;
        rand_bp = 1'b1;
        for (int b = 0; b < 300; b++) begin
            d = {8'h00, 8'($urandom)}; n = $urandom_range(0, 7); dir = 1'($urandom); m = 2'($urandom);
            send(8, d, n, dir, m, ref_shift(8, d, n, dir, m));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rand_bp = 1'b0;
        repeat (20) @(posedge clk); #1;

        checks += 2;
        if (q8.size() != 0)  fail_line("drain8", 16'(q8.size()), 16'h0);
        if (q16.size() != 0) fail_line("drain16", 16'(q16.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
